// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key event block.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } key_state_t;

    localparam int unsigned TICK_DIV_DEF  = 100000;
    localparam int unsigned LONG_MS_DEF   = 1000;
    localparam int unsigned REPEAT_MS_DEF = 200;

endpackage

// File: rtl/key_event_if.sv
// Debounced key level in, single-cycle key events and held level out.
interface key_event_if;

    logic key_n;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic key_held;

    modport master (
        output key_n,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  key_held
    );

    modport slave (
        input  key_n,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output repeat_pulse,
        output key_held
    );

endinterface

// File: rtl/key_event_tick_gen.sv
// Clearable prescaler: tick is high for one cycle every TICK_DIV enabled cycles.
module tick_gen #(
    parameter int unsigned TICK_DIV = key_pkg::TICK_DIV_DEF
) (
    input  logic clk_100M,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [DW-1:0] div_cnt;

    assign tick = en && (div_cnt == DW'(TICK_DIV - 1));

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event.sv
// Turns a debounced active-low key level into press/release/long/repeat pulses.
module key_event
    import key_pkg::*;
#(
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned LONG_MS   = LONG_MS_DEF,
    parameter int unsigned REPEAT_MS = REPEAT_MS_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic         clk_100M,
    input  logic         rst,
    key_event_if.slave   kif
);

    key_state_t state, state_nxt;

    logic             key_q;
    logic             fall, rise, tick, tick_clr, tick_en;
    logic [CNT_W-1:0] ms_cnt, ms_nxt, rep_cnt, rep_nxt;
    logic             press_q, release_q, long_q, repeat_q, held_q;
    logic             press_nxt, release_nxt, long_nxt, repeat_nxt, held_nxt;

    assign fall    = key_q & ~kif.key_n;
    assign rise    = ~key_q & kif.key_n;
    assign tick_en = (state != IDLE);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_100M (clk_100M),
        .rst      (rst),
        .clr      (tick_clr),
        .en       (tick_en),
        .tick     (tick)
    );

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_q     <= 1'b1;
            ms_cnt    <= '0;
            rep_cnt   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            key_q     <= kif.key_n;
            ms_cnt    <= ms_nxt;
            rep_cnt   <= rep_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            long_q    <= long_nxt;
            repeat_q  <= repeat_nxt;
            held_q    <= held_nxt;
        end
    end

    // Release is tested before the tick so a coinciding tick is dropped.
    always_comb begin
        state_nxt   = state;
        ms_nxt      = ms_cnt;
        rep_nxt     = rep_cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        held_nxt    = held_q;
        tick_clr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                    held_nxt  = 1'b1;
                    tick_clr  = 1'b1;
                    ms_nxt    = '0;
                end
            end
            HELD: begin
                if (rise) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    held_nxt    = 1'b0;
                end else if (tick) begin
                    ms_nxt = ms_cnt + 1'b1;
                    if (ms_nxt == CNT_W'(LONG_MS)) begin
                        state_nxt = LONG;
                        long_nxt  = 1'b1;
                        rep_nxt   = '0;
                    end
                end
            end
            LONG: begin
                if (rise) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    held_nxt    = 1'b0;
                end else if (tick) begin
                    if (rep_cnt + 1'b1 == CNT_W'(REPEAT_MS)) begin
                        repeat_nxt = 1'b1;
                        rep_nxt    = '0;
                    end else begin
                        rep_nxt = rep_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                held_nxt  = 1'b0;
            end
        endcase
    end

    assign kif.press_pulse   = press_q;
    assign kif.release_pulse = release_q;
    assign kif.long_pulse    = long_q;
    assign kif.repeat_pulse  = repeat_q;
    assign kif.key_held      = held_q;

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Consumer end of the debounced key line: takes the active-low, debounced key level from the key debouncer and converts it into single-cycle event pulses for the control logic.
- Events are press, release, long-press and auto-repeat.
- Sits between each debounced key and the menu/mode FSMs, so those FSMs never time key holds themselves.

Parameters:
- TICK_DIV, 100000, clk_100M cycles per hold-timing tick (100000 cycles = 1 ms at 100 MHz); must be ≥2.
- LONG_MS, 1000, ticks of continuous hold before long_pulse; must be ≥1 and <2^CNT_W.
- REPEAT_MS, 200, ticks between repeat_pulse events after long_pulse; must be ≥1 and <2^CNT_W.
- CNT_W, 16, width of the tick counters.

Ports:
- clk_100M  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- key_n  input  1  debounced key level, synchronous to clk_100M; 0 = pressed.
- press_pulse  output  1  one-cycle pulse on press.
- release_pulse  output  1  one-cycle pulse on release.
- long_pulse  output  1  one-cycle pulse when the hold reaches LONG_MS ticks.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_MS ticks after long_pulse while still held.
- key_held  output  1  level; 1 from press_pulse until release_pulse.

Behaviour:
- Clock and reset: one clock, clk_100M. Reset is asynchronous, active-high.
- Reset values:
  - all outputs 0
  - key_q = 1
  - div_cnt = 0, ms_cnt = 0, rep_cnt = 0
  - state = IDLE
- Edges: key_q is key_n delayed by one cycle.
  - fall = key_q & ~key_n
  - rise = ~key_q & key_n
- States: IDLE, HELD, LONG.
- IDLE:
  - On fall: go to HELD. press_pulse and key_held are registered, so they assert in the cycle after key_n is first sampled low. Call that cycle P.
  - On the same edge, clear div_cnt and ms_cnt.
- Tick generation: in HELD and LONG, div_cnt counts 0..TICK_DIV-1 and wraps. tick = (div_cnt == TICK_DIV-1). The first tick occurs TICK_DIV cycles after P.
- HELD:
  - Each tick increments ms_cnt.
  - When the increment makes ms_cnt == LONG_MS: long_pulse = 1 for one cycle at P+LONG_MS*TICK_DIV, go to LONG, clear rep_cnt.
- LONG:
  - Each tick increments rep_cnt.
  - When rep_cnt reaches REPEAT_MS: repeat_pulse = 1 for one cycle, clear rep_cnt.
  - Repeat pulses occur at P+(LONG_MS+k*REPEAT_MS)*TICK_DIV, k ≥ 1.
  - ms_cnt holds at LONG_MS; it never wraps.
- Release: rise in HELD or LONG gives release_pulse = 1 for one cycle, key_held = 0 on the same cycle, go to IDLE, and freezes the counters.
- Simultaneous events: rise on the same cycle as a tick that would produce long_pulse or repeat_pulse means release wins. Only release_pulse fires and the tick is discarded.
- Pulse exclusivity: at most one of press_pulse, release_pulse, long_pulse and repeat_pulse is high in any cycle.
- Short presses: a press shorter than LONG_MS ticks produces press_pulse and release_pulse only.
- Reset mid-operation:
  - Asserting rst returns to IDLE immediately and drops key_held with no release_pulse.
  - If key_n is still 0 after rst deasserts, the reset value key_q = 1 makes the next cycle a fall, so a fresh press_pulse is generated.
- No combinational path from key_n to any output.

Decomposition:
- Shared package key_pkg:
  - state enum (IDLE, HELD, LONG)
  - default constants TICK_DIV_DEF = 100000, LONG_MS_DEF = 1000, REPEAT_MS_DEF = 200
- One natural sub-module, tick_gen: a clearable TICK_DIV prescaler.
  - inputs: clk_100M, rst, clr, en
  - output: tick
- The FSM, hold counters and edge detection stay in key_event.

Test Plan:
All scenarios use TICK_DIV=10, LONG_MS=5 and REPEAT_MS=3; cycle numbers count from reset release at cycle 0.
- Short press: key_n low at cycles 20–39 → press_pulse at cycle 21, release_pulse at cycle 41, no long_pulse, key_held = 1 for cycles 21–40.
- Long hold: key_n low from cycle 20 to 150 → press_pulse at 21, long_pulse at 71, repeat_pulse at 101 and 131, release_pulse at 152.
- Release/long collision: key_n rises so that rise coincides with the long tick at cycle 71 → release_pulse only at 71, no long_pulse, state = IDLE.
- Reset mid-hold: key_n low from cycle 20; rst pulsed at cycles 60–61 → all outputs 0 during rst, no release_pulse, fresh press_pulse at 63, long_pulse at 113.
- Back-to-back presses: low for cycles 20–24, high 25–26, low from 27 → press, release, press at cycles 21, 26, 28. Timing restarts, so long_pulse lands at 78.
- Exclusivity check: assertion across all tests that the four pulses are never simultaneously high and each pulse is exactly 1 cycle wide.
